// File: rtl/load_ext_stage.sv
// MEM/WB load-data stage: selects the addressed byte/halfword from the memory word,
// zero/sign-extends it, flags and counts misaligned loads, and registers the result.
module load_ext_stage #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [2:0]       ld_op,
  input  logic [1:0]       addr_lo,
  input  logic [31:0]      rdata,
  input  logic [4:0]       rd,
  input  logic             reg_write,
  output logic             out_valid,
  output logic [31:0]      out_data,
  output logic [4:0]       out_rd,
  output logic             out_we,
  output logic             misalign,
  output logic [CNT_W-1:0] misalign_cnt
);

  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_BU = 3'd1,
    LD_B  = 3'd2,
    LD_HU = 3'd3,
    LD_H  = 3'd4
  } ld_op_e;

  ld_op_e           op;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [31:0]      ext_data;
  logic             is_mis;

  logic             valid_d, valid_q;
  logic [31:0]      data_d, data_q;
  logic [4:0]       rd_d, rd_q;
  logic             we_d, we_q;
  logic             mis_d, mis_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    op       = ld_op_e'(ld_op);
    byte_sel = rdata[7:0];
    ext_data = rdata;
    is_mis   = 1'b0;

    case (addr_lo)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (op)
      LD_W: begin
        ext_data = rdata;
        is_mis   = (addr_lo != 2'd0);
      end
      LD_BU:   ext_data = {24'h0, byte_sel};
      LD_B:    ext_data = {{24{byte_sel[7]}}, byte_sel};
      LD_HU: begin
        ext_data = {16'h0, half_sel};
        is_mis   = addr_lo[0];
      end
      LD_H: begin
        ext_data = {{16{half_sel[15]}}, half_sel};
        is_mis   = addr_lo[0];
      end
      default: ext_data = rdata;  // non-loads carry the ALU result through
    endcase

    valid_d = in_valid;
    rd_d    = rd;
    data_d  = is_mis ? 32'h0 : ext_data;
    mis_d   = in_valid & is_mis;
    we_d    = in_valid & reg_write & (rd != 5'd0) & ~is_mis;
    cnt_d   = (mis_d && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: reset is synchronous and clears every register, including the counter; there is no memory here.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= 32'h0;
      rd_q    <= 5'd0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (flush) begin
      // Bubble: clear the instruction fields but keep the running misalignment count.
      valid_q <= 1'b0;
      data_q  <= 32'h0;
      rd_q    <= 5'd0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
    end else if (!stall) begin
      valid_q <= valid_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_data     = data_q;
  assign out_rd       = rd_q;
  assign out_we       = we_q;
  assign misalign     = mis_q;
  assign misalign_cnt = cnt_q;

endmodule

// File: tb/tb_load_ext_stage.sv
// Directed bench for load_ext_stage; a second instance with a 2-bit counter
// shares the stimulus to exercise counter saturation at a small width.
module tb_load_ext_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, stall, flush, reg_write;
  logic [2:0]  ld_op;
  logic [1:0]  addr_lo;
  logic [31:0] rdata;
  logic [4:0]  rd;

  logic        out_valid, out_we, misalign;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic [7:0]  misalign_cnt;

  logic        out_valid2, out_we2, misalign2;
  logic [31:0] out_data2;
  logic [4:0]  out_rd2;
  logic [1:0]  misalign_cnt2;

  int vectors = 0;
  int miscompares = 0;

  // {out_valid, out_we, misalign, out_rd, out_data}
  logic [39:0] obs;
  assign obs = {out_valid, out_we, misalign, out_rd, out_data};

  always #5 clk = ~clk;

  load_ext_stage #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .ld_op(ld_op), .addr_lo(addr_lo), .rdata(rdata), .rd(rd), .reg_write(reg_write),
    .out_valid(out_valid), .out_data(out_data), .out_rd(out_rd), .out_we(out_we),
    .misalign(misalign), .misalign_cnt(misalign_cnt)
  );

  load_ext_stage #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .ld_op(ld_op), .addr_lo(addr_lo), .rdata(rdata), .rd(rd), .reg_write(reg_write),
    .out_valid(out_valid2), .out_data(out_data2), .out_rd(out_rd2), .out_we(out_we2),
    .misalign(misalign2), .misalign_cnt(misalign_cnt2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [1:0] a,
                       input logic [31:0] d, input logic [4:0] r, input logic w);
    in_valid  = v;
    ld_op     = op;
    addr_lo   = a;
    rdata     = d;
    rd        = r;
    reg_write = w;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b1, 3'd0, 2'd2, 32'hCAFEF00D, 5'd9, 1'b1);
    step(); step();
    vectors++;
    if (obs !== 40'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected %h", obs, 40'h0);
    end
    vectors++;
    if (misalign_cnt !== 8'd0 || misalign_cnt2 !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_cnt: got %0d/%0d expected 0/0", misalign_cnt, misalign_cnt2);
    end
    reset = 1'b0;
  endtask

  task automatic test_byte_loads();
    logic [31:0] exp_lb [4];
    logic [31:0] exp_lbu [4];
    exp_lb  = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80};
    exp_lbu = '{32'h00000001, 32'h0000007F, 32'h000000FF, 32'h00000080};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'd2, 2'(i), 32'h80FF7F01, 5'd5, 1'b1);
      step();
      vectors++;
      if (obs !== {3'b110, 5'd5, exp_lb[i]}) begin
        miscompares++;
        $display("FAIL lb_addr%0d: got %h expected %h", i, obs, {3'b110, 5'd5, exp_lb[i]});
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'd1, 2'(i), 32'h80FF7F01, 5'd5, 1'b1);
      step();
      vectors++;
      if (obs !== {3'b110, 5'd5, exp_lbu[i]}) begin
        miscompares++;
        $display("FAIL lbu_addr%0d: got %h expected %h", i, obs, {3'b110, 5'd5, exp_lbu[i]});
      end
    end
  endtask

  task automatic test_half_loads();
    drive(1'b1, 3'd4, 2'd0, 32'h8001FFFF, 5'd6, 1'b1);
    step();
    vectors++;
    if (obs !== {3'b110, 5'd6, 32'hFFFFFFFF}) begin
      miscompares++;
      $display("FAIL lh_addr0: got %h expected %h", obs, {3'b110, 5'd6, 32'hFFFFFFFF});
    end
    drive(1'b1, 3'd4, 2'd2, 32'h8001FFFF, 5'd6, 1'b1);
    step();
    vectors++;
    if (obs !== {3'b110, 5'd6, 32'hFFFF8001}) begin
      miscompares++;
      $display("FAIL lh_addr2: got %h expected %h", obs, {3'b110, 5'd6, 32'hFFFF8001});
    end
    drive(1'b1, 3'd3, 2'd2, 32'h8001FFFF, 5'd6, 1'b1);
    step();
    vectors++;
    if (obs !== {3'b110, 5'd6, 32'h00008001}) begin
      miscompares++;
      $display("FAIL lhu_addr2: got %h expected %h", obs, {3'b110, 5'd6, 32'h00008001});
    end
    drive(1'b1, 3'd4, 2'd1, 32'h8001FFFF, 5'd6, 1'b1);
    step();
    vectors++;
    if (obs !== {3'b101, 5'd6, 32'h0} || misalign_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL lh_misaligned: got %h cnt %0d expected %h cnt 1",
               obs, misalign_cnt, {3'b101, 5'd6, 32'h0});
    end
  endtask

  task automatic test_misalign_count();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd0, 2'd2, 32'h11223344, 5'd8, 1'b1);
      step();
    end
    vectors++;
    if (misalign_cnt !== 8'd3 || misalign_cnt2 !== 2'd3 || obs !== {3'b101, 5'd8, 32'h0}) begin
      miscompares++;
      $display("FAIL lw_mis_x3: got cnt %0d/%0d obs %h expected cnt 3/3 obs %h",
               misalign_cnt, misalign_cnt2, obs, {3'b101, 5'd8, 32'h0});
    end
    for (int i = 0; i < 2; i++) step();
    vectors++;
    if (misalign_cnt !== 8'd5 || misalign_cnt2 !== 2'd3) begin
      miscompares++;
      $display("FAIL cnt2_saturate: got %0d/%0d expected 5/3", misalign_cnt, misalign_cnt2);
    end
    for (int i = 0; i < 252; i++) step();
    vectors++;
    if (misalign_cnt !== 8'd255) begin
      miscompares++;
      $display("FAIL cnt8_reach_max: got %0d expected 255", misalign_cnt);
    end
    step(); step();
    vectors++;
    if (misalign_cnt !== 8'd255 || misalign_cnt2 !== 2'd3) begin
      miscompares++;
      $display("FAIL cnt8_saturate: got %0d/%0d expected 255/3", misalign_cnt, misalign_cnt2);
    end
    // Byte loads at odd offsets never count as misaligned.
    drive(1'b1, 3'd2, 2'd3, 32'h80FF7F01, 5'd4, 1'b1);
    do_reset();
    step();
    vectors++;
    if (misalign !== 1'b0 || misalign_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL lb_odd_not_mis: got mis %b cnt %0d expected 0 0", misalign, misalign_cnt);
    end
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 3'd0, 2'd0, 32'h12345678, 5'd7, 1'b1);
    step();
    vectors++;
    if (obs !== {3'b110, 5'd7, 32'h12345678}) begin
      miscompares++;
      $display("FAIL lw_capture: got %h expected %h", obs, {3'b110, 5'd7, 32'h12345678});
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      // Changing inputs, including a misaligned load that must not be counted.
      drive(1'b1, 3'd0, 2'(i + 1), 32'hA5A5A5A5 + 32'(i), 5'(10 + i), 1'b1);
      step();
      vectors++;
      if (obs !== {3'b110, 5'd7, 32'h12345678} || misalign_cnt !== 8'd0) begin
        miscompares++;
        $display("FAIL stall_hold%0d: got %h cnt %0d expected %h cnt 0",
                 i, obs, misalign_cnt, {3'b110, 5'd7, 32'h12345678});
      end
    end
    flush = 1'b1;
    step();
    vectors++;
    if (obs !== 40'h0 || misalign_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL flush_over_stall: got %h cnt %0d expected %h cnt 0", obs, misalign_cnt, 40'h0);
    end
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_we_and_passthru();
    drive(1'b1, 3'd0, 2'd0, 32'h0BADF00D, 5'd0, 1'b1);
    step();
    vectors++;
    if (obs !== {3'b100, 5'd0, 32'h0BADF00D}) begin
      miscompares++;
      $display("FAIL lw_rd0: got %h expected %h", obs, {3'b100, 5'd0, 32'h0BADF00D});
    end
    drive(1'b1, 3'd6, 2'd3, 32'hDEADBEEF, 5'd3, 1'b1);
    step();
    vectors++;
    if (obs !== {3'b110, 5'd3, 32'hDEADBEEF}) begin
      miscompares++;
      $display("FAIL op6_passthru: got %h expected %h", obs, {3'b110, 5'd3, 32'hDEADBEEF});
    end
    drive(1'b1, 3'd4, 2'd2, 32'h7FFF0000, 5'd12, 1'b0);
    step();
    vectors++;
    if (obs !== {3'b100, 5'd12, 32'h00007FFF}) begin
      miscompares++;
      $display("FAIL lh_no_regwrite: got %h expected %h", obs, {3'b100, 5'd12, 32'h00007FFF});
    end
    drive(1'b0, 3'd2, 2'd1, 32'h0000A500, 5'd9, 1'b1);
    step();
    vectors++;
    if (obs !== {3'b000, 5'd9, 32'hFFFFFFA5}) begin
      miscompares++;
      $display("FAIL invalid_capture: got %h expected %h", obs, {3'b000, 5'd9, 32'hFFFFFFA5});
    end
    drive(1'b0, 3'd0, 2'd1, 32'h55555555, 5'd9, 1'b1);
    step();
    vectors++;
    if ({out_valid, out_we, misalign} !== 3'b000 || misalign_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL invalid_mis_ignored: got %b cnt %0d expected 000 cnt 0",
               {out_valid, out_we, misalign}, misalign_cnt);
    end
  endtask

  task automatic test_reset_mid_stall();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'd3, 2'd1, 32'hFFFF0000, 5'd14, 1'b1);
      step();
    end
    vectors++;
    if (misalign_cnt !== 8'd4 || misalign_cnt2 !== 2'd3) begin
      miscompares++;
      $display("FAIL pre_reset_cnt: got %0d/%0d expected 4/3", misalign_cnt, misalign_cnt2);
    end
    stall = 1'b1;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    vectors++;
    if (obs !== 40'h0 || misalign_cnt !== 8'd0 || misalign_cnt2 !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_mid_stall: got %h cnt %0d/%0d expected %h cnt 0/0",
               obs, misalign_cnt, misalign_cnt2, 40'h0);
    end
    stall = 1'b0;
    drive(1'b1, 3'd1, 2'd3, 32'hC3000000, 5'd1, 1'b1);
    step();
    vectors++;
    if (obs !== {3'b110, 5'd1, 32'h000000C3}) begin
      miscompares++;
      $display("FAIL first_after_reset: got %h expected %h", obs, {3'b110, 5'd1, 32'h000000C3});
    end
  endtask

  initial begin
    test_reset();
    test_byte_loads();
    test_half_loads();
    test_misalign_count();
    test_stall_flush();
    test_we_and_passthru();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
